hazard_control: RTL and testbench
=================================

Name: hazard_control

Overview:
- Pipeline sequencing unit for the filter processor's F/Reg, Reg/Exe and Exe/Mem pipeline registers.
- Handles the hazards that forwarding cannot resolve:
  - load-use interlock: multi-cycle stall plus bubble insertion;
  - taken-branch flush;
  - full-pipeline freeze while a data-memory access is unacknowledged.
- Sits beside the forwarding unit. Drives stall/flush enables of the pipeline registers and the PC.

Parameters:
- REG_W, 4, register index width.
- LOAD_DELAY, 1, stall cycles inserted per load-use hazard; legal 1..7.
- PERF_W, 16, width of the saturating stall-cycle counter.
- TIMEOUT, 255, freeze-cycle limit; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous reset, active-low.
- Ra_Reg  in  REG_W  source A of instruction in Reg stage.
- RE_A_Reg  in  1  source A is read.
- Rb_Reg  in  REG_W  source B of instruction in Reg stage.
- RE_B_Reg  in  1  source B is read.
- Robj_Exe  in  REG_W  destination of instruction in Exe stage.
- mem_RE_Exe  in  1  instruction in Exe is a load.
- branch_taken_Exe  in  1  branch in Exe resolved taken.
- mem_req_Mem  in  1  Mem-stage instruction accesses data memory.
- mem_ack  in  1  data memory completes access this cycle.
- stall_PC  out  1  hold PC.
- stall_F_Reg  out  1  hold F/Reg register.
- stall_Reg_Exe  out  1  hold Reg/Exe register.
- stall_Exe_Mem  out  1  hold Exe/Mem register.
- flush_F_Reg  out  1  load NOP into F/Reg.
- flush_Reg_Exe  out  1  load NOP into Reg/Exe.
- stall_cnt  out  PERF_W  saturating count of cycles with stall_PC=1.
- mem_timeout  out  1  sticky freeze-timeout flag.

Behaviour:
- State register (RUN=0, LOAD_STALL=1), counter cnt[2:0], stall_cnt.
- Reset (async, rst_n=0):
  - state=RUN, cnt=0, stall_cnt=0, mem_timeout=0.
  - All stall/flush outputs decode to 0 while held in reset.
- Control outputs are combinational (Mealy) from state and inputs. Zero-latency: asserted in the same cycle as the hazard.
- Definitions:
  - freeze = mem_req_Mem & ~mem_ack.
  - load_use = mem_RE_Exe & ((RE_A_Reg & Ra_Reg==Robj_Exe) | (RE_B_Reg & Rb_Reg==Robj_Exe)).
- Priority, highest first: freeze > branch_taken_Exe > load_use/LOAD_STALL.
- freeze, any state:
  - stall_PC = stall_F_Reg = stall_Reg_Exe = stall_Exe_Mem = 1; both flushes 0.
  - state and cnt hold. Branch and load_use are ignored that cycle; they are re-evaluated when freeze drops.
  - A freeze that ends with mem_ack=1 applies normal logic in that same cycle.
- RUN, branch_taken_Exe=1:
  - flush_F_Reg = flush_Reg_Exe = 1; no stalls; stay RUN.
  - A branch suppresses a simultaneous load_use.
- RUN, load_use=1:
  - stall_PC = stall_F_Reg = 1, flush_Reg_Exe = 1 (bubble).
  - If LOAD_DELAY==1: stay RUN.
  - Else: cnt <= LOAD_DELAY-1, go to LOAD_STALL.
- LOAD_STALL, no freeze:
  - stall_PC = stall_F_Reg = 1, flush_Reg_Exe = 1.
  - branch_taken_Exe is a don't-care here, since Exe holds a bubble.
  - cnt <= cnt-1. When cnt==1 this is the last stall cycle; next state RUN.
  - Total stall per hazard = exactly LOAD_DELAY cycles.
- RUN, no hazard: all control outputs 0.
- stall_cnt:
  - Increments on every clock edge where stall_PC=1.
  - Saturates at 2^PERF_W-1; no wrap-around.
- Reset asserted mid-stall or mid-freeze returns to RUN immediately. No pending stall survives reset.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - Counter fcnt (8 bits) counts consecutive freeze cycles and clears on any non-freeze cycle.
  - When fcnt reaches TIMEOUT, mem_timeout sets to 1 and stays set until rst_n.
  - Pipeline behaviour is unchanged; freeze still holds the pipeline.
- Undefined: no fcnt is instantiated; mem_timeout is tied to 0.

Test Plan:
- Load-use, LOAD_DELAY=1: mem_RE_Exe=1, Robj_Exe=3, Ra_Reg=3, RE_A_Reg=1 -> same cycle stall_PC=stall_F_Reg=flush_Reg_Exe=1 for 1 cycle; stall_cnt=1.
- Load-use, LOAD_DELAY=3: Rb_Reg=5, RE_B_Reg=1, Robj_Exe=5, load for one cycle -> stall/bubble asserted exactly 3 cycles, then RUN; stall_cnt=3. Same match with RE_B_Reg=0 -> no stall.
- Branch vs load-use same cycle: branch_taken_Exe=1 with load_use true -> flush_F_Reg=flush_Reg_Exe=1, stall_PC=0, state stays RUN.
- Freeze inside LOAD_STALL: LOAD_DELAY=3, mem_req_Mem=1, mem_ack=0 for 4 cycles starting in the 2nd stall cycle -> all four stalls=1 for 4 cycles, cnt held; after mem_ack=1 the remaining 2 load-stall cycles complete; stall_cnt=7.
- Reset mid-LOAD_STALL: rst_n=0 asynchronously -> outputs 0 immediately; state=RUN, stall_cnt=0 after release.
- MEM_TIMEOUT_EN with TIMEOUT=4: freeze held 4 cycles -> mem_timeout=1 and stays 1 after mem_ack; freeze of 3 cycles -> mem_timeout stays 0.

Source files
------------

// File: rtl/hazard_control_if.sv
// Hazard-control bus: Reg/Exe/Mem hazard sources in, pipeline-register
// stall/flush enables, stall-cycle counter and freeze-timeout flag out.
// master = pipeline side that supplies hazard information,
// slave  = the hazard_control unit.
interface hazard_control_if #(
  parameter int REG_W  = 4,
  parameter int PERF_W = 16
) ();
  logic [REG_W-1:0]  Ra_Reg;
  logic              RE_A_Reg;
  logic [REG_W-1:0]  Rb_Reg;
  logic              RE_B_Reg;
  logic [REG_W-1:0]  Robj_Exe;
  logic              mem_RE_Exe;
  logic              branch_taken_Exe;
  logic              mem_req_Mem;
  logic              mem_ack;
  logic              stall_PC;
  logic              stall_F_Reg;
  logic              stall_Reg_Exe;
  logic              stall_Exe_Mem;
  logic              flush_F_Reg;
  logic              flush_Reg_Exe;
  logic [PERF_W-1:0] stall_cnt;
  logic              mem_timeout;

  modport master (
    output Ra_Reg, RE_A_Reg, Rb_Reg, RE_B_Reg, Robj_Exe, mem_RE_Exe,
           branch_taken_Exe, mem_req_Mem, mem_ack,
    input  stall_PC, stall_F_Reg, stall_Reg_Exe, stall_Exe_Mem,
           flush_F_Reg, flush_Reg_Exe, stall_cnt, mem_timeout
  );

  modport slave (
    input  Ra_Reg, RE_A_Reg, Rb_Reg, RE_B_Reg, Robj_Exe, mem_RE_Exe,
           branch_taken_Exe, mem_req_Mem, mem_ack,
    output stall_PC, stall_F_Reg, stall_Reg_Exe, stall_Exe_Mem,
           flush_F_Reg, flush_Reg_Exe, stall_cnt, mem_timeout
  );
endinterface

// File: rtl/hazard_control.sv
// hazard_control: pipeline sequencing for the F/Reg, Reg/Exe and Exe/Mem
// registers. Resolves the hazards forwarding cannot: load-use interlock
// (LOAD_DELAY stall cycles with a bubble), taken-branch flush, and a full
// freeze while a data-memory access is unacknowledged.
// Control outputs are Mealy: they react in the same cycle as the hazard.
// Optional: define MEM_TIMEOUT_EN to add the freeze watchdog (fcnt) that
// sets the sticky mem_timeout flag after TIMEOUT consecutive freeze cycles.
module hazard_control #(
  parameter int REG_W      = 4,
  parameter int LOAD_DELAY = 1,
  parameter int PERF_W     = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_control_if.slave  bus
);

  typedef enum logic {
    RUN        = 1'b0,
    LOAD_STALL = 1'b1
  } state_t;

  // Stall cycles still owed after the hazard cycle itself.
  localparam logic [2:0] STALL_EXTRA = 3'(LOAD_DELAY - 1);

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        cnt;
  logic [2:0]        cnt_nxt;
  logic [PERF_W-1:0] stall_cnt;
  logic [REG_W-1:0]  ra;
  logic [REG_W-1:0]  rb;
  logic [REG_W-1:0]  robj;
  logic              freeze;
  logic              load_use;

  assign ra   = bus.Ra_Reg;
  assign rb   = bus.Rb_Reg;
  assign robj = bus.Robj_Exe;

  // Memory not yet acknowledged holds everything; a cycle with mem_ack
  // proceeds normally.
  assign freeze   = bus.mem_req_Mem & ~bus.mem_ack;
  assign load_use = bus.mem_RE_Exe &
                    ((bus.RE_A_Reg & (ra == robj)) | (bus.RE_B_Reg & (rb == robj)));

  // State register: sequencing state and remaining load-stall count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: freeze holds state and count; a branch in RUN
  // suppresses the load-use interlock.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!freeze) begin
      case (state)
        RUN: begin
          if (!bus.branch_taken_Exe && load_use && (LOAD_DELAY > 1)) begin
            state_nxt = LOAD_STALL;
            cnt_nxt   = STALL_EXTRA;
          end
        end
        LOAD_STALL: begin
          cnt_nxt = cnt - 3'd1;
          if (cnt == 3'd1) begin
            state_nxt = RUN;
          end
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  // Output decode: freeze > branch > load-use/LOAD_STALL; all zero in reset.
  always_comb begin
    bus.stall_PC      = 1'b0;
    bus.stall_F_Reg   = 1'b0;
    bus.stall_Reg_Exe = 1'b0;
    bus.stall_Exe_Mem = 1'b0;
    bus.flush_F_Reg   = 1'b0;
    bus.flush_Reg_Exe = 1'b0;
    if (rst_n) begin
      if (freeze) begin
        bus.stall_PC      = 1'b1;
        bus.stall_F_Reg   = 1'b1;
        bus.stall_Reg_Exe = 1'b1;
        bus.stall_Exe_Mem = 1'b1;
      end else if (state == LOAD_STALL) begin
        // Exe holds a bubble here, so a branch indication is meaningless.
        bus.stall_PC      = 1'b1;
        bus.stall_F_Reg   = 1'b1;
        bus.flush_Reg_Exe = 1'b1;
      end else if (bus.branch_taken_Exe) begin
        bus.flush_F_Reg   = 1'b1;
        bus.flush_Reg_Exe = 1'b1;
      end else if (load_use) begin
        bus.stall_PC      = 1'b1;
        bus.stall_F_Reg   = 1'b1;
        bus.flush_Reg_Exe = 1'b1;
      end
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (bus.stall_PC && (stall_cnt != {PERF_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(PERF_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.stall_cnt = stall_cnt;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] fcnt;
  logic       timeout_flag;

  // Watchdog: count consecutive freeze cycles; flag sticks once the
  // count reaches TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt         <= 8'd0;
      timeout_flag <= 1'b0;
    end else begin
      if (freeze) begin
        if (fcnt != 8'hFF) begin
          fcnt <= fcnt + 8'd1;
        end
        if (({1'b0, fcnt} + 9'd1) == 9'(TIMEOUT)) begin
          timeout_flag <= 1'b1;
        end
      end else begin
        fcnt <= 8'd0;
      end
    end
  end

  assign bus.mem_timeout = timeout_flag;
`else
  assign bus.mem_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Directed testbench for hazard_control. Two instances share clk/rst_n:
// u_d1 (LOAD_DELAY=1, PERF_W=2 to reach counter saturation) and
// u_d3 (LOAD_DELAY=3, TIMEOUT=4). Inputs change 1 time unit after the
// rising edge; outputs are sampled 1 unit after the inputs change.
module tb_hazard_control;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  hazard_control_if #(.REG_W(4), .PERF_W(2))  if1 ();
  hazard_control_if #(.REG_W(4), .PERF_W(16)) if3 ();

  hazard_control #(.REG_W(4), .LOAD_DELAY(1), .PERF_W(2), .TIMEOUT(4)) u_d1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  hazard_control #(.REG_W(4), .LOAD_DELAY(3), .PERF_W(16), .TIMEOUT(4)) u_d3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stall_PC, stall_F_Reg, stall_Reg_Exe, stall_Exe_Mem, flush_F_Reg, flush_Reg_Exe}
  function automatic logic [5:0] ctl1();
    return {if1.stall_PC, if1.stall_F_Reg, if1.stall_Reg_Exe, if1.stall_Exe_Mem,
            if1.flush_F_Reg, if1.flush_Reg_Exe};
  endfunction

  function automatic logic [5:0] ctl3();
    return {if3.stall_PC, if3.stall_F_Reg, if3.stall_Reg_Exe, if3.stall_Exe_Mem,
            if3.flush_F_Reg, if3.flush_Reg_Exe};
  endfunction

  localparam logic [5:0] NONE   = 6'b000000;
  localparam logic [5:0] LSTALL = 6'b110001;
  localparam logic [5:0] FRZ    = 6'b111100;
  localparam logic [5:0] BFLUSH = 6'b000011;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_all();
    if1.Ra_Reg = '0; if1.RE_A_Reg = 1'b0; if1.Rb_Reg = '0; if1.RE_B_Reg = 1'b0;
    if1.Robj_Exe = '0; if1.mem_RE_Exe = 1'b0; if1.branch_taken_Exe = 1'b0;
    if1.mem_req_Mem = 1'b0; if1.mem_ack = 1'b0;
    if3.Ra_Reg = '0; if3.RE_A_Reg = 1'b0; if3.Rb_Reg = '0; if3.RE_B_Reg = 1'b0;
    if3.Robj_Exe = '0; if3.mem_RE_Exe = 1'b0; if3.branch_taken_Exe = 1'b0;
    if3.mem_req_Mem = 1'b0; if3.mem_ack = 1'b0;
  endtask

  // Load in Exe writing r3, Reg-stage instruction reads r3 on port A.
  task automatic load_a1();
    if1.mem_RE_Exe = 1'b1; if1.Robj_Exe = 4'd3; if1.Ra_Reg = 4'd3; if1.RE_A_Reg = 1'b1;
  endtask

  task automatic load_a3();
    if3.mem_RE_Exe = 1'b1; if3.Robj_Exe = 4'd3; if3.Ra_Reg = 4'd3; if3.RE_A_Reg = 1'b1;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b0;
    clear_all();
    settle();

    // Reset state, and outputs forced low while a hazard is present in reset
    chk("rst_ctl1", 32'(ctl1()), 32'(NONE));
    chk("rst_ctl3", 32'(ctl3()), 32'(NONE));
    chk("rst_cnt1", 32'(if1.stall_cnt), 32'd0);
    chk("rst_cnt3", 32'(if3.stall_cnt), 32'd0);
    chk("rst_tmo", 32'(if3.mem_timeout), 32'd0);
    load_a1();
    settle();
    chk("rst_decode_zero", 32'(ctl1()), 32'(NONE));
    tick();
    clear_all();
    tick();
    rst_n = 1'b1;
    settle();

    // Load-use, LOAD_DELAY=1: single stall+bubble, stays RUN
    load_a1();
    settle();
    chk("lu1_hazard", 32'(ctl1()), 32'(LSTALL));
    tick();
    clear_all();
    settle();
    chk("lu1_after", 32'(ctl1()), 32'(NONE));
    chk("lu1_cnt", 32'(if1.stall_cnt), 32'd1);

    // Load-use on port B, LOAD_DELAY=3: exactly three stall cycles
    if3.mem_RE_Exe = 1'b1; if3.Robj_Exe = 4'd5; if3.Rb_Reg = 4'd5; if3.RE_B_Reg = 1'b1;
    settle();
    chk("lu3_c0", 32'(ctl3()), 32'(LSTALL));
    tick();
    clear_all();
    settle();
    chk("lu3_c1", 32'(ctl3()), 32'(LSTALL));
    tick();
    chk("lu3_c2", 32'(ctl3()), 32'(LSTALL));
    tick();
    chk("lu3_c3_run", 32'(ctl3()), 32'(NONE));
    chk("lu3_cnt", 32'(if3.stall_cnt), 32'd3);

    // Same register match but port B not read: no hazard
    if3.mem_RE_Exe = 1'b1; if3.Robj_Exe = 4'd5; if3.Rb_Reg = 4'd5; if3.RE_B_Reg = 1'b0;
    settle();
    chk("nore_b", 32'(ctl3()), 32'(NONE));
    tick();
    clear_all();
    settle();
    chk("nore_b_next", 32'(ctl3()), 32'(NONE));
    chk("nore_b_cnt", 32'(if3.stall_cnt), 32'd3);

    // Branch and load-use together: flush only, remain in RUN
    load_a3();
    if3.branch_taken_Exe = 1'b1;
    settle();
    chk("br_lu", 32'(ctl3()), 32'(BFLUSH));
    tick();
    clear_all();
    settle();
    chk("br_lu_run", 32'(ctl3()), 32'(NONE));
    chk("br_lu_cnt", 32'(if3.stall_cnt), 32'd3);

    // Freeze for 4 cycles starting in the 2nd load-stall cycle
    load_a3();
    settle();
    chk("fz_c0", 32'(ctl3()), 32'(LSTALL));
    tick();
    clear_all();
    if3.mem_req_Mem = 1'b1;
    if3.mem_ack     = 1'b0;
    settle();
    chk("fz_f1", 32'(ctl3()), 32'(FRZ));
    tick();
    chk("fz_f2", 32'(ctl3()), 32'(FRZ));
    tick();
    chk("fz_f3", 32'(ctl3()), 32'(FRZ));
    tick();
    chk("fz_f4", 32'(ctl3()), 32'(FRZ));
    tick();
    if3.mem_ack = 1'b1;
    settle();
    chk("fz_ack_stall", 32'(ctl3()), 32'(LSTALL));
    tick();
    if3.mem_req_Mem = 1'b0;
    if3.mem_ack     = 1'b0;
    settle();
    chk("fz_last_stall", 32'(ctl3()), 32'(LSTALL));
    tick();
    chk("fz_run", 32'(ctl3()), 32'(NONE));
    chk("fz_cnt", 32'(if3.stall_cnt), 32'd10);

    // Asynchronous reset in the middle of LOAD_STALL
    load_a3();
    settle();
    tick();
    clear_all();
    settle();
    chk("rs_in_stall", 32'(ctl3()), 32'(LSTALL));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_async_ctl", 32'(ctl3()), 32'(NONE));
    chk("rs_async_cnt", 32'(if3.stall_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    settle();
    chk("rs_rel_ctl", 32'(ctl3()), 32'(NONE));
    tick();
    chk("rs_rel_run", 32'(ctl3()), 32'(NONE));
    chk("rs_rel_cnt3", 32'(if3.stall_cnt), 32'd0);
    chk("rs_rel_cnt1", 32'(if1.stall_cnt), 32'd0);

    // Saturation: PERF_W=2 counter stops at 3 under continuous hazard
    load_a1();
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    chk("sat_ctl", 32'(ctl1()), 32'(LSTALL));
    chk("sat_cnt", 32'(if1.stall_cnt), 32'd3);
    clear_all();
    tick();
    chk("sat_hold", 32'(if1.stall_cnt), 32'd3);

`ifdef MEM_TIMEOUT_EN
    // 3-cycle freeze stays below TIMEOUT=4
    if3.mem_req_Mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
    end
    if3.mem_ack = 1'b1;
    settle();
    chk("tmo_3_clear", 32'(if3.mem_timeout), 32'd0);
    tick();
    clear_all();
    tick();
    chk("tmo_3_after", 32'(if3.mem_timeout), 32'd0);
    // 4-cycle freeze reaches TIMEOUT and the flag sticks
    if3.mem_req_Mem = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    if3.mem_ack = 1'b1;
    settle();
    chk("tmo_4_set", 32'(if3.mem_timeout), 32'd1);
    tick();
    clear_all();
    tick();
    chk("tmo_sticky", 32'(if3.mem_timeout), 32'd1);
`else
    // Without the watchdog a long freeze never raises mem_timeout
    if3.mem_req_Mem = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
    end
    chk("notmo_frz", 32'(ctl3()), 32'(FRZ));
    chk("notmo_flag", 32'(if3.mem_timeout), 32'd0);
    clear_all();
    tick();
    chk("notmo_after", 32'(if3.mem_timeout), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
